// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] X0_REG = 5'd0;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic       uses_rs2);
    return memread && (rd != X0_REG) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and pipeline-register control bundle; master = pipeline side, slave = controller.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32) ();

  logic             memread_ex;
  logic [4:0]       rd_ex;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             uses_rs2_id;
  logic             branch_mem;
  logic             zero_mem;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             ex_mem_flush;
  logic             mem_wb_write;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output memread_ex, rd_ex, rs1_id, rs2_id, uses_rs2_id,
           branch_mem, zero_mem, dmem_req, dmem_ready,
    input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write, halted,
           stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  memread_ex, rd_ex, rs1_id, rs2_id, uses_rs2_id,
           branch_mem, zero_mem, dmem_req, dmem_ready,
    output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write, halted,
           stall_cnt, flush_cnt, memwait_cnt
  );

endinterface

// File: rtl/pipe_perf_counters.sv
// Wrapping event counters for load-use stalls, branch flushes and dmem wait cycles.
module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             memwait_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  // Counter registers, one increment per strobed cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
      memwait_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc)   stall_cnt   <= stall_cnt + CNT_W'(1);
      if (flush_inc)   flush_cnt   <= flush_cnt + CNT_W'(1);
      if (memwait_inc) memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer with dmem-wait timeout halt.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  import pipe_ctrl_pkg::*;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_r;
  logic [WAIT_W-1:0] wait_ctr_r;
  logic              mem_stall_s;
  logic              taken_s;
  logic              lu_s;
  logic [9:0]        ctrl_s;

  assign mem_stall_s = ((state_r == RUN) && hz.dmem_req && !hz.dmem_ready) ||
                       ((state_r == MEM_WAIT) && !hz.dmem_ready);
  assign taken_s     = hz.branch_mem && hz.zero_mem;
  assign lu_s        = load_use_hit(hz.memread_ex, hz.rd_ex, hz.rs1_id,
                                    hz.rs2_id, hz.uses_rs2_id);

  // Control vector {pc_write, pc_src, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, mem_wb_w, halted}.
  always_comb begin
    ctrl_s = 10'b1_0_1_0_1_0_1_0_1_0;
    if (reset) begin
      ctrl_s = 10'b0_0_0_1_0_1_0_1_0_0;
    end else if (state_r == ERR) begin
      ctrl_s = 10'b0_0_0_0_0_0_0_0_0_1;
    end else if (mem_stall_s) begin
      ctrl_s = 10'b0_0_0_0_0_0_0_0_0_0;
    end else if (taken_s) begin
      ctrl_s = 10'b1_1_1_1_1_1_1_1_1_0;
    end else if (lu_s) begin
      ctrl_s = 10'b0_0_0_0_1_1_1_0_1_0;
    end else begin
      ctrl_s = 10'b1_0_1_0_1_0_1_0_1_0;
    end
  end

  assign {hz.pc_write, hz.pc_src, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
          hz.id_ex_flush, hz.ex_mem_write, hz.ex_mem_flush, hz.mem_wb_write,
          hz.halted} = ctrl_s;

  // State machine; wait_ctr_r counts frozen cycles of the current dmem access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      wait_ctr_r <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (hz.dmem_req && !hz.dmem_ready) begin
            state_r    <= MEM_WAIT;
            wait_ctr_r <= WAIT_W'(1);
          end else begin
            state_r    <= RUN;
            wait_ctr_r <= {WAIT_W{1'b0}};
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state_r    <= RUN;
            wait_ctr_r <= {WAIT_W{1'b0}};
          end else if (wait_ctr_r == WAIT_W'(MEM_TIMEOUT)) begin
            state_r    <= ERR;
          end else begin
            wait_ctr_r <= wait_ctr_r + WAIT_W'(1);
          end
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r    <= ERR;
          wait_ctr_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic active_s;
  assign active_s = !reset && (state_r != ERR);

  pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .stall_inc   (active_s && !mem_stall_s && !taken_s && lu_s),
    .flush_inc   (active_s && !mem_stall_s && taken_s),
    .memwait_inc (active_s && mem_stall_s),
    .stall_cnt   (hz.stall_cnt),
    .flush_cnt   (hz.flush_cnt),
    .memwait_cnt (hz.memwait_cnt)
  );
`else
  assign hz.stall_cnt   = {CNT_W{1'b0}};
  assign hz.flush_cnt   = {CNT_W{1'b0}};
  assign hz.memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule
